// File: rtl/bbot_quadrature_velocity_meter.sv
// Quadrature velocity meter: samples a free-running 32-bit position count once per
// window and reports the saturated signed delta, a 4-window moving average, the
// direction of the last nonzero delta and a stall flag.
module bbot_quadrature_velocity_meter #(
   parameter int unsigned SAMPLE_PERIOD = 50000,
   parameter int unsigned STALL_WINDOWS = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic [31:0]        count_in,
   output logic signed [15:0] velocity,
   output logic signed [15:0] velocity_avg,
   output logic               velocity_valid,
   output logic               direction,
   output logic               stalled,
   output logic               saturated
);

   localparam int unsigned     CntW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_PERIOD - 1);
   localparam logic [7:0]      ZMax   = 8'(STALL_WINDOWS);

   typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [31:0]            prev_q, prev_d;
   logic [3:0][15:0]       hist_q, hist_d;
   logic signed [15:0]     vel_q, vel_d;
   logic signed [15:0]     avg_q, avg_d;
   logic                   valid_q, valid_d;
   logic                   dir_q, dir_d;
   logic                   stall_q, stall_d;
   logic                   sat_q, sat_d;
   logic [7:0]             zrun_q, zrun_d;

   logic                   tick;
   logic signed [31:0]     delta;
   logic signed [15:0]     vel_clamp;
   logic                   clamp_hit;
   logic signed [17:0]     sum;

   assign tick = (cnt_q == CntMax);

   // Window delta (modular, so counter wrap is seamless), clamp and new 4-entry sum.
   always_comb begin
      delta     = $signed(count_in - prev_q);
      clamp_hit = 1'b1;
      if (delta > 32'sd32767) begin
         vel_clamp = 16'sh7fff;
      end else if (delta < -32'sd32768) begin
         vel_clamp = 16'sh8000;
      end else begin
         vel_clamp = delta[15:0];
         clamp_hit = 1'b0;
      end
      sum = {{2{vel_clamp[15]}}, vel_clamp}
          + $signed({{2{hist_q[0][15]}}, hist_q[0]})
          + $signed({{2{hist_q[1][15]}}, hist_q[1]})
          + $signed({{2{hist_q[2][15]}}, hist_q[2]});
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: enable low always returns to idle; PRIME only waits for one window.
   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:  state_d = StPrime;
            StPrime: if (tick) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StIdle;
         endcase
      end
   end

   // Datapath next state: window counter, baseline, measurement outputs.
   always_comb begin
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      hist_d  = hist_q;
      vel_d   = vel_q;
      avg_d   = avg_q;
      valid_d = 1'b0;
      dir_d   = dir_q;
      stall_d = stall_q;
      sat_d   = sat_q;
      zrun_d  = zrun_q;
      if (!enable || state_q == StIdle) begin
         cnt_d   = '0;
         hist_d  = '0;
         vel_d   = '0;
         avg_d   = '0;
         dir_d   = 1'b0;
         stall_d = 1'b0;
         zrun_d  = '0;
         // Saturation is sticky through idle and only cleared when a new run starts.
         if (enable) sat_d = 1'b0;
      end else begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
         if (tick) begin
            prev_d = count_in;
            if (state_q == StRun) begin
               vel_d   = vel_clamp;
               hist_d  = {hist_q[2:0], vel_clamp};
               avg_d   = 16'(sum >>> 2);
               valid_d = 1'b1;
               if (clamp_hit) sat_d = 1'b1;
               if (delta > 0) dir_d = 1'b1;
               else if (delta < 0) dir_d = 1'b0;
               if (delta == 0) zrun_d = (zrun_q >= ZMax) ? zrun_q : zrun_q + 8'd1;
               else zrun_d = '0;
               stall_d = (zrun_d >= ZMax);
            end
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         prev_q  <= '0;
         hist_q  <= '0;
         vel_q   <= '0;
         avg_q   <= '0;
         valid_q <= 1'b0;
         dir_q   <= 1'b0;
         stall_q <= 1'b0;
         sat_q   <= 1'b0;
         zrun_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         hist_q  <= hist_d;
         vel_q   <= vel_d;
         avg_q   <= avg_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         stall_q <= stall_d;
         sat_q   <= sat_d;
         zrun_q  <= zrun_d;
      end
   end

   assign velocity       = vel_q;
   assign velocity_avg   = avg_q;
   assign velocity_valid = valid_q;
   assign direction      = dir_q;
   assign stalled        = stall_q;
   assign saturated      = sat_q;

endmodule
